// File: rtl/comparador_serial_izq_der.sv
// Serial MSB-first unsigned comparator: one bit per clock, relation absorbing.
// Optional EARLY_EXIT_EN: finish on the edge where the words first differ.
module comparador_serial_izq_der #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         gt,
  output logic         lt,
  output logic         eq
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    REL_EQ,
    REL_GT,
    REL_LT
  } rel_e;

  state_e        state_q, state_d;
  rel_e          rel_q, rel_d, rel_n;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [2:0]    res_q, res_d;
  logic          fin;

  always_comb begin
    state_d = state_q;
    rel_d   = rel_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    res_d   = res_q;
    fin     = 1'b0;
    rel_n   = rel_q;
    if (rel_q == REL_EQ) begin
      if (a_q[idx_q] && !b_q[idx_q]) rel_n = REL_GT;
      else if (!a_q[idx_q] && b_q[idx_q]) rel_n = REL_LT;
    end
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          rel_d   = REL_EQ;
          idx_d   = IW'(N - 1);
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        rel_d = rel_n;
        fin   = (idx_q == '0);
`ifdef EARLY_EXIT_EN
        if (rel_n != REL_EQ) fin = 1'b1;
`endif
        if (fin) begin
          state_d = DONE;
          res_d   = {rel_n == REL_GT,
                     rel_n == REL_LT,
                     rel_n == REL_EQ};
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rel_q   <= REL_EQ;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rel_q   <= rel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign gt   = res_q[2];
  assign lt   = res_q[1];
  assign eq   = res_q[0];

endmodule

// File: doc/comparador_serial_izq_der.md
COMPARADOR_SERIAL_IZQ_DER -- requirements
Module: comparador_serial_izq_der

Interface
REQ-001 Parameter: N, default 8, word width in bits; legal range N >= 2.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to compare a against b; sampled on rising edge.
REQ-005 a  input  N  word A, captured only on the edge that accepts start.
REQ-006 b  input  N  word B, captured only on the edge that accepts start.
REQ-007 busy  output  1  high while a comparison is in progress (SHIFT state).
REQ-008 done  output  1  one-cycle pulse, result valid.
REQ-009 gt  output  1  registered result, A > B.
REQ-010 lt  output  1  registered result, A < B.
REQ-011 eq  output  1  registered result, A == B.

Function
REQ-012 The block SHALL compare A and B unsigned, one bit per clock, MSB (bit N-1) first down to bit 0, as the sequential form of the left-to-right iterative comparator network.
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 In IDLE or DONE, start=1 SHALL capture a and b, set the working relation to EQUAL, set the bit index to N-1, and move to SHIFT.
REQ-015 In SHIFT, start SHALL be ignored and SHALL NOT disturb captured words, index or working relation.
REQ-016 Each SHIFT edge SHALL process bit[index]:
- relation EQUAL and A[i]=1, B[i]=0 -> GT.
- relation EQUAL and A[i]=0, B[i]=1 -> LT.
- relation GT or LT is absorbing and SHALL NOT change.
REQ-017 After processing index 0, the FSM SHALL move to DONE.
REQ-018 The bit index counter SHALL be clog2(N) bits wide and SHALL NOT wrap below 0.
REQ-019 Latency: the k-th SHIFT edge processes bit N-k. done SHALL be high during the cycle after the N-th edge following the start-accepting edge.
REQ-020 gt/lt/eq SHALL load from the working relation on the SHIFT->DONE edge and SHALL be one-hot from then on.
REQ-021 gt/lt/eq SHALL hold their value until the next SHIFT->DONE transition. They SHALL keep the previous result during busy.
REQ-022 busy=1 exactly in SHIFT. done=1 exactly in DONE, which SHALL last one cycle.
REQ-023 DONE with start=0 SHALL go to IDLE. DONE with start=1 SHALL go directly to SHIFT (back-to-back operation, no idle cycle).

Reset
REQ-024 When rst_n=0, the block SHALL asynchronously force state IDLE, busy=0, done=0, gt=0, lt=0, eq=0, index=0 and relation EQUAL.
REQ-025 Reset asserted mid-SHIFT SHALL abort the comparison with no done pulse.
REQ-026 The first start after rst_n rises SHALL be accepted normally.

Configuration
REQ-027 Macro EARLY_EXIT_EN, when defined: if the working relation becomes GT or LT on an edge, that same edge SHALL move SHIFT->DONE.
- Latency becomes N-i edges, where i is the index of the first differing bit.
- Equal words still take N edges.
REQ-028 When EARLY_EXIT_EN is undefined, latency SHALL always be N edges regardless of the data.

Verification
REQ-029 N=8, a=0xA5, b=0xA5, start one cycle -> busy for 8 cycles, done after 8th edge; eq=1, gt=0, lt=0.
REQ-030 N=8, a=0x80, b=0x7F -> gt=1. With EARLY_EXIT_EN: done after 1st edge, busy for 1 cycle. Without it: done after 8th edge.
REQ-031 N=8, a=0x12, b=0x13 -> lt=1, done after 8th edge in both configurations.
REQ-032 Start held high throughout, with a/b changed every cycle during busy -> inputs ignored during busy. Results use the words captured at acceptance. A new comparison starts on the DONE edge with no IDLE cycle.
REQ-033 rst_n pulsed low at the 4th SHIFT edge of a=0xFF, b=0x00 -> outputs 0 immediately, no done pulse. Next start with a=0x01, b=0x02 -> lt=1.
